port_periph: RTL and testbench
==============================

# port_periph

Port-side responder for the single-cycle CPU's 4-port I/O bus. Decodes CPU port writes into an output GPIO register, a scratch register and a programmable 8-bit interval timer. Continuously drives the four CPU input ports and raises the CPU's `i_timer` interrupt on timer expiry. Instantiated next to `cpu` in the board top, sharing its clock and reset.

## Interface
- `PRESCALE`, default 1000: clock cycles per timer count. Legal values are ≥2.
- `PW`, default 10: prescaler counter width. Must satisfy 2^PW ≥ PRESCALE.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `we_o` input 1: CPU port-write strobe.
- `hilo_out` input 2: port number written by the CPU.
- `out_p0`..`out_p3` input 8 each: CPU output port buses. Write data is `out_p[hilo_out]`.
- `sw` input 8: external switches.
- `in_p0`..`in_p3` output 8 each: to the CPU input ports.
- `gpio` output 8: LED/GPIO output register.
- `i_timer` output 1: interrupt pulse to the CPU.

## Operation
- Write decode: when `we_o`=1 at a clock edge, the port selected by `hilo_out` is written with `out_p[hilo_out]`. When `we_o`=0, nothing is written.
- Port 0 write: `gpio` <= data.
- Port 1 write: `reload` <= data, `count` <= data, prescaler <= 0.
- Port 2 write (control):
  - `en` <= bit0.
  - `auto` <= bit1.
  - bit7=1 clears `pending`. Bit 7 is write-1-to-clear and is not stored.
  - Bits 6..2 are ignored.
- Port 3 write: `scratch` <= data.
- Read side, all four buses continuous (no strobe, no read side effects):
  - `in_p0` = `sw` (see Configuration).
  - `in_p1` = `count`.
  - `in_p2` = {`pending`, 5'b0, `auto`, `en`}.
  - `in_p3` = `scratch`.
- Timer behaviour, with `en`=1:
  - The prescaler counts 0..PRESCALE-1.
  - At PRESCALE-1 it wraps to 0 and a tick occurs.
  - On a tick with `count`>1: `count` decrements.
  - On a tick with `count`=1: expiry.
  - On a tick with `count`=0: no action. The timer never expires while `reload`=0.
- Expiry:
  - `pending` <= 1.
  - `i_timer` is high for exactly the next cycle.
  - If `auto`=1: `count` <= `reload`.
  - If `auto`=0: `count` <= 0 and `en` <= 0 (one-shot).
- With `en`=0, the prescaler and `count` hold their values. Setting `en` resumes without clearing either.
- Period in auto mode is `reload`×PRESCALE cycles, measured expiry to expiry.

## Timing
- Reset values: `gpio`, `scratch`, `reload`, `count`, prescaler, `en`, `auto`, `pending` and `i_timer` are all 0.
  - Hence `in_p1`..`in_p3` = 0.
  - `in_p0` follows `sw` per Configuration.
- Register writes are visible on `gpio`/`in_p*` one cycle after the write edge.
- Expiry latency:
  - `pending` and `i_timer` assert in the cycle after the tick edge.
  - `i_timer` deasserts one cycle later. It is never held for 2 or more cycles, even if `pending` stays set.
- Simultaneous events:
  - Port-1 write on a tick or expiry cycle: the write wins. No expiry, `count`=data, prescaler=0.
  - Port-2 clear (bit7=1) on an expiry cycle: the expiry wins and `pending` stays 1. `i_timer` still pulses.
  - Port-2 write with en=0 on an expiry cycle: `en`=0 and the expiry is still reported.
- A reset asserted mid-count aborts the count. It forces the reset values on the next edge and suppresses any pending `i_timer` pulse.

## Configuration
- `PORT_PERIPH_SYNC_EN` defined:
  - `sw` passes through a 2-flop synchronizer before `in_p0`.
  - Latency is 2 cycles.
  - Sync flops reset to 0.
- Not defined: `in_p0` = `sw` combinationally, with 0 latency and no flops.

## Test plan
- Reset check: assert `reset` 2 cycles with `sw`=8'hA5 -> `gpio`=0, `in_p1`..`in_p3`=0, `i_timer`=0. `in_p0`=8'hA5 after 2 cycles (SYNC_EN) or immediately (without it).
- Port writes: `we_o`=1 with `hilo_out`=0/3 and `out_p0`=8'h3C / `out_p3`=8'h77 -> `gpio`=8'h3C, `in_p3`=8'h77 next cycle. With `we_o`=0 and the same buses, nothing changes.
- Auto-reload (PRESCALE=4): write port1=3, then port2=8'h03 -> `i_timer` pulses every 12 cycles, each pulse 1 cycle wide. `in_p2`=8'h83 after the first expiry. `in_p1` sequence is 3,2,1,3.
- One-shot (PRESCALE=4): write port1=2, then port2=8'h01 -> a single pulse after 8 cycles. Then `en`=0, `count`=0, `in_p2`=8'h80, with no further pulses over 50 cycles.
- Clear vs expiry: port2=8'h83 written on the expiry edge -> `pending` remains 1. A port2=8'h83 written 3 cycles later -> `in_p2`=8'h03.
- Edge cases: reload=0 with `en`=1 gives no pulse over 100 cycles. A port-1 write on a tick cycle gives no pulse and the count restarts from the written value.

Source files
------------

// File: rtl/port_periph.sv
// I/O-bus responder for the single-cycle CPU: GPIO, scratch and an 8-bit interval timer with interrupt.
// Optional `PORT_PERIPH_SYNC_EN: 2-flop synchronizer on sw before in_p0.
module port_periph #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned PW       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we_o,
    input  logic [1:0] hilo_out,
    input  logic [7:0] out_p0,
    input  logic [7:0] out_p1,
    input  logic [7:0] out_p2,
    input  logic [7:0] out_p3,
    input  logic [7:0] sw,
    output logic [7:0] in_p0,
    output logic [7:0] in_p1,
    output logic [7:0] in_p2,
    output logic [7:0] in_p3,
    output logic [7:0] gpio,
    output logic       i_timer
);

    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [7:0]    gpio_q, gpio_d;
    logic [7:0]    scratch_q, scratch_d;
    logic [7:0]    reload_q, reload_d;
    logic [7:0]    count_q, count_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          en_q, en_d;
    logic          auto_q, auto_d;
    logic          pending_q, pending_d;
    logic          irq_q, irq_d;

    logic [7:0] wr_data;
    logic       wr0, wr1, wr2, wr3;
    logic       tick, expire;

    always_comb begin
        wr_data = out_p0;
        case (hilo_out)
            2'd0: wr_data = out_p0;
            2'd1: wr_data = out_p1;
            2'd2: wr_data = out_p2;
            2'd3: wr_data = out_p3;
            default: wr_data = out_p0;
        endcase
        wr0 = we_o && (hilo_out == 2'd0);
        wr1 = we_o && (hilo_out == 2'd1);
        wr2 = we_o && (hilo_out == 2'd2);
        wr3 = we_o && (hilo_out == 2'd3);
    end

    always_comb begin
        tick   = en_q && (pre_q == PRE_MAX);
        // A reload write on the same edge overrides the expiry entirely.
        expire = tick && (count_q == 8'd1) && !wr1;

        gpio_d    = gpio_q;
        scratch_d = scratch_q;
        reload_d  = reload_q;
        count_d   = count_q;
        pre_d     = pre_q;
        en_d      = en_q;
        auto_d    = auto_q;
        pending_d = pending_q;
        irq_d     = expire;

        if (en_q) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
        if (tick && (count_q > 8'd1)) begin
            count_d = count_q - 8'd1;
        end
        if (expire) begin
            pending_d = 1'b1;
            if (auto_q) begin
                count_d = reload_q;
            end else begin
                count_d = '0;
                en_d    = 1'b0;
            end
        end

        if (wr0) gpio_d = wr_data;
        if (wr1) begin
            reload_d = wr_data;
            count_d  = wr_data;
            pre_d    = '0;
        end
        if (wr2) begin
            en_d   = wr_data[0];
            auto_d = wr_data[1];
            // Write-1-to-clear loses against a simultaneous expiry.
            if (wr_data[7] && !expire) pending_d = 1'b0;
        end
        if (wr3) scratch_d = wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q    <= '0;
            scratch_q <= '0;
            reload_q  <= '0;
            count_q   <= '0;
            pre_q     <= '0;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            gpio_q    <= gpio_d;
            scratch_q <= scratch_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            pre_q     <= pre_d;
            en_q      <= en_d;
            auto_q    <= auto_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

`ifdef PORT_PERIPH_SYNC_EN
    logic [7:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
        end
    end

    assign in_p0 = sync2_q;
`else
    assign in_p0 = sw;
`endif

    assign in_p1   = count_q;
    assign in_p2   = {pending_q, 5'b0, auto_q, en_q};
    assign in_p3   = scratch_q;
    assign gpio    = gpio_q;
    assign i_timer = irq_q;

endmodule

// File: tb/tb_port_periph.sv
// Scoreboard bench for port_periph: per-cycle expected outputs from a reference model, checked by a monitor.
module tb_port_periph;

    localparam int unsigned P = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       we_o;
    logic [1:0] hilo_out;
    logic [7:0] out_p0, out_p1, out_p2, out_p3, sw;
    logic [7:0] in_p0, in_p1, in_p2, in_p3, gpio;
    logic       i_timer;

    always #5 clk = ~clk;

    port_periph #(.PRESCALE(P), .PW(3)) dut (
        .clk(clk), .reset(reset), .we_o(we_o), .hilo_out(hilo_out),
        .out_p0(out_p0), .out_p1(out_p1), .out_p2(out_p2), .out_p3(out_p3),
        .sw(sw), .in_p0(in_p0), .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3),
        .gpio(gpio), .i_timer(i_timer)
    );

    typedef struct {
        logic [7:0] p0, p1, p2, p3, gp;
        logic       irq;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: architectural state of the peripheral after the latest edge.
    int         m_gpio, m_scratch, m_reload, m_count, m_elapsed;
    bit         m_en, m_auto, m_pend, m_irq;
    logic [7:0] m_s1, m_s2;
    logic [7:0] cur_sw;

    function automatic void model_reset();
        m_gpio = 0; m_scratch = 0; m_reload = 0; m_count = 0; m_elapsed = 0;
        m_en = 0; m_auto = 0; m_pend = 0; m_irq = 0;
        m_s1 = '0; m_s2 = '0;
    endfunction

    function automatic bit model_tick_next();
        return m_en && (m_elapsed == P - 1);
    endfunction

    function automatic bit model_fire_next();
        return model_tick_next() && (m_count == 1);
    endfunction

    function automatic void model_step(input bit rst, input bit we, input logic [1:0] port,
                                       input logic [7:0] d, input logic [7:0] swv);
        bit tick, fire;
        if (rst) begin
            model_reset();
            return;
        end
        m_s2 = m_s1;
        m_s1 = swv;
        tick = model_tick_next();
        fire = tick && (m_count == 1) && !(we && port == 2'd1);
        m_irq = fire;
        if (m_en) m_elapsed = (m_elapsed + 1) % P;
        if (tick && m_count > 1) m_count = m_count - 1;
        if (fire) begin
            m_pend = 1;
            if (m_auto) m_count = m_reload;
            else begin
                m_count = 0;
                m_en = 0;
            end
        end
        if (we) begin
            case (port)
                2'd0: m_gpio = int'(d);
                2'd1: begin m_reload = int'(d); m_count = int'(d); m_elapsed = 0; end
                2'd2: begin
                    m_en = d[0];
                    m_auto = d[1];
                    if (d[7] && !fire) m_pend = 0;
                end
                default: m_scratch = int'(d);
            endcase
        end
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] want);
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            cmp("in_p0", in_p0, e.p0);
            cmp("in_p1", in_p1, e.p1);
            cmp("in_p2", in_p2, e.p2);
            cmp("in_p3", in_p3, e.p3);
            cmp("gpio", gpio, e.gp);
            cmp("i_timer", {7'b0, i_timer}, {7'b0, e.irq});
        end
    end

    task automatic cyc(input bit rst, input bit we, input logic [1:0] port,
                       input logic [7:0] d, input logic [7:0] swv);
        exp_t e;
        @(posedge clk);
        #1;
        reset  = rst;
        we_o   = we;
        hilo_out = port;
        out_p0 = 8'($urandom);
        out_p1 = 8'($urandom);
        out_p2 = 8'($urandom);
        out_p3 = 8'($urandom);
        case (port)
            2'd0: out_p0 = d;
            2'd1: out_p1 = d;
            2'd2: out_p2 = d;
            default: out_p3 = d;
        endcase
        sw = swv;
        cur_sw = swv;
`ifdef PORT_PERIPH_SYNC_EN
        e.p0 = m_s2;
`else
        e.p0 = swv;
`endif
        e.p1  = 8'(m_count);
        e.p2  = {m_pend, 5'b0, m_auto, m_en};
        e.p3  = 8'(m_scratch);
        e.gp  = 8'(m_gpio);
        e.irq = m_irq;
        exp_q.push_back(e);
        model_step(rst, we, port, d, swv);
    endtask

    task automatic wr(input logic [1:0] port, input logic [7:0] d);
        cyc(1'b0, 1'b1, port, d, cur_sw);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'($urandom), 8'($urandom), cur_sw);
    endtask

    // Idles until the model predicts a tick (or expiry) on the upcoming edge.
    task automatic wait_event(input bit want_fire, input string name);
        int n = 0;
        while (!(want_fire ? model_fire_next() : model_tick_next()) && n < 100) begin
            idle(1);
            n++;
        end
        if (n >= 100) begin
            miscompares++;
            $display("FAIL %s: event not reached within 100 cycles", name);
        end
    endtask

    initial begin
        reset = 1'b1; we_o = 1'b0; hilo_out = '0;
        out_p0 = '0; out_p1 = '0; out_p2 = '0; out_p3 = '0;
        sw = 8'hA5; cur_sw = 8'hA5;
        model_reset();

        cyc(1'b1, 1'b0, 2'd0, 8'h00, 8'hA5);
        cyc(1'b1, 1'b0, 2'd0, 8'h00, 8'hA5);
        idle(3);

        wr(2'd0, 8'h3C);
        wr(2'd3, 8'h77);
        cyc(1'b0, 1'b0, 2'd0, 8'h55, cur_sw);
        cyc(1'b0, 1'b0, 2'd3, 8'h11, cur_sw);
        idle(2);

        wr(2'd1, 8'd3);
        wr(2'd2, 8'h03);
        idle(40);
        wr(2'd2, 8'h80);
        idle(3);

        wr(2'd1, 8'd2);
        wr(2'd2, 8'h01);
        idle(60);

        wr(2'd1, 8'd3);
        wr(2'd2, 8'h03);
        wait_event(1'b1, "expiry_for_clear");
        wr(2'd2, 8'h83);
        idle(2);
        wr(2'd2, 8'h83);
        idle(3);

        wr(2'd1, 8'd0);
        wr(2'd2, 8'h01);
        idle(100);

        wr(2'd1, 8'd3);
        wr(2'd2, 8'h03);
        wait_event(1'b0, "tick_for_reload");
        wr(2'd1, 8'd2);
        idle(5);
        wait_event(1'b1, "expiry_for_reload");
        wr(2'd1, 8'd3);
        idle(20);

        wr(2'd1, 8'd1);
        wr(2'd2, 8'h01);
        wait_event(1'b1, "oneshot_en_write");
        wr(2'd2, 8'h00);
        idle(4);

        wr(2'd1, 8'd5);
        wr(2'd2, 8'h03);
        idle(9);
        cyc(1'b1, 1'b0, 2'd0, 8'h00, cur_sw);
        idle(5);

        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic [1:0]  port;
            logic [7:0]  d;
            r = $urandom_range(0, 99);
            port = 2'($urandom);
            d = 8'($urandom);
            if (port == 2'd1) d = 8'($urandom_range(0, 4));
            if (port == 2'd2) begin
                d[0] = ($urandom_range(0, 4) != 0);
                d[7] = ($urandom_range(0, 4) == 0);
            end
            if (r < 2) cyc(1'b1, 1'b0, port, d, 8'($urandom));
            else if (r < 20) cyc(1'b0, 1'b1, port, d, 8'($urandom));
            else cyc(1'b0, 1'b0, port, d, 8'($urandom));
        end

        idle(1);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
